sda_kernel_job_arbiter: RTL and testbench



---
 rtl/sda_kernel_job_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_sda_kernel_job_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sda_kernel_job_arbiter.sv
// sda_kernel_job_arbiter
//
// Shares one kernel go/done control interface between NumReq requesters.
// One job is in flight at a time. Grants are round-robin and start searching
// just after the requester that last completed a job. The go token is forwarded
// to the kernel, and the done token is routed back to the owning requester only.
// The kernel-side port drives the register-side go/done interface of the
// kernel reset handler.
//
// Handshakes: a go transfers on valid & ~holdoff. A done transfers on
// valid & ~stop.
//
// Ports
//   clk              system clock
//   sysRstReq        synchronous active-high reset
//   reqGoValid       [NumReq] per-requester go request (held until accepted)
//   reqGoHoldoff     [NumReq] per-requester go holdoff (low only for the grantee)
//   reqDoneValid     [NumReq] per-requester done notification (owner only)
//   reqDoneStop      [NumReq] per-requester done stop
//   kernelGoValid    go towards the kernel / reset handler
//   kernelGoHoldoff  kernel go holdoff
//   kernelDoneValid  kernel done
//   kernelDoneStop   kernel done stop (low only while a job is running)
//   activeOwner      index of the current or last granted requester
//   busy             high whenever the arbiter is not idle
//   watchdogExpired  sticky flag for a job that ran too long
//
// Optional feature: define SDA_JOB_ARB_WATCHDOG_EN to build the running-job
// watchdog. Without it, watchdogExpired is tied low.
//
// All outputs are registered.

module sda_kernel_job_arbiter #(
  parameter int NumReq            = 4,
  parameter int OwnerWidth        = 2,
  parameter int WatchdogCountSize = 16
) (
  input  logic                  clk,
  input  logic                  sysRstReq,
  input  logic [NumReq-1:0]     reqGoValid,
  output logic [NumReq-1:0]     reqGoHoldoff,
  output logic [NumReq-1:0]     reqDoneValid,
  input  logic [NumReq-1:0]     reqDoneStop,
  output logic                  kernelGoValid,
  input  logic                  kernelGoHoldoff,
  input  logic                  kernelDoneValid,
  output logic                  kernelDoneStop,
  output logic [OwnerWidth-1:0] activeOwner,
  output logic                  busy,
  output logic                  watchdogExpired
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACCEPT  = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_RUNNING = 3'd3,
    ST_RETURN  = 3'd4
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [OwnerWidth-1:0] last_owner;
  logic [OwnerWidth-1:0] winner;

  logic                  kernel_go_fire;
  logic                  kernel_done_fire;
  logic                  req_done_fire;

  logic [NumReq-1:0]     go_holdoff_next;
  logic [NumReq-1:0]     done_valid_next;
  logic                  kernel_go_next;
  logic                  kernel_stop_next;
  logic [OwnerWidth-1:0] owner_next;
  logic [OwnerWidth-1:0] last_owner_next;

  // Round-robin pick: the first asserted request at last+1, last+2, ...
  // (mod NumReq). Walking the offsets from farthest to nearest lets the
  // nearest asserted index overwrite the others. The last owner itself
  // is therefore the lowest-priority candidate.
  function automatic logic [OwnerWidth-1:0] rr_pick(
    input logic [NumReq-1:0]     req,
    input logic [OwnerWidth-1:0] last
  );
    logic [OwnerWidth-1:0] pick;
    int                    idx;
    pick = '0;
    for (int k = NumReq; k >= 1; k--) begin
      idx = (int'(last) + k) % NumReq;
      if (req[idx]) pick = OwnerWidth'(idx);
    end
    return pick;
  endfunction

  assign winner           = rr_pick(reqGoValid, last_owner);
  assign kernel_go_fire   = kernelGoValid & ~kernelGoHoldoff;
  assign kernel_done_fire = kernelDoneValid & ~kernelDoneStop;
  assign req_done_fire    = reqDoneValid[activeOwner] & ~reqDoneStop[activeOwner];

  // State register together with the registered outputs
  always_ff @(posedge clk) begin
    if (sysRstReq) begin
      state          <= ST_IDLE;
      reqGoHoldoff   <= '1;
      reqDoneValid   <= '0;
      kernelGoValid  <= 1'b0;
      kernelDoneStop <= 1'b1;
      activeOwner    <= '0;
      last_owner     <= OwnerWidth'(NumReq - 1);
      busy           <= 1'b0;
    end else begin
      state          <= state_next;
      reqGoHoldoff   <= go_holdoff_next;
      reqDoneValid   <= done_valid_next;
      kernelGoValid  <= kernel_go_next;
      kernelDoneStop <= kernel_stop_next;
      activeOwner    <= owner_next;
      last_owner     <= last_owner_next;
      busy           <= (state_next != ST_IDLE);
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:    if (|reqGoValid) state_next = ST_ACCEPT;
      // A dropped request while granted is a protocol violation: abandon the
      // grant without touching last_owner.
      ST_ACCEPT:  state_next = reqGoValid[activeOwner] ? ST_ISSUE : ST_IDLE;
      ST_ISSUE:   if (kernel_go_fire) state_next = ST_RUNNING;
      ST_RUNNING: if (kernel_done_fire) state_next = ST_RETURN;
      ST_RETURN:  if (req_done_fire) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Output logic: computes the values the output registers take next
  always_comb begin
    go_holdoff_next  = '1;
    done_valid_next  = reqDoneValid;
    kernel_go_next   = kernelGoValid;
    kernel_stop_next = kernelDoneStop;
    owner_next       = activeOwner;
    last_owner_next  = last_owner;
    unique case (state)
      ST_IDLE: begin
        if (|reqGoValid) begin
          owner_next              = winner;
          go_holdoff_next[winner] = 1'b0;
        end
      end
      ST_ACCEPT: begin
        // The go transfers this cycle because the holdoff is already low.
        if (reqGoValid[activeOwner]) kernel_go_next = 1'b1;
      end
      ST_ISSUE: begin
        if (kernel_go_fire) begin
          kernel_go_next   = 1'b0;
          kernel_stop_next = 1'b0;
        end
      end
      ST_RUNNING: begin
        if (kernel_done_fire) begin
          kernel_stop_next             = 1'b1;
          done_valid_next[activeOwner] = 1'b1;
        end
      end
      ST_RETURN: begin
        if (req_done_fire) begin
          done_valid_next = '0;
          last_owner_next = activeOwner;
        end
      end
      default: ;
    endcase
  end

`ifdef SDA_JOB_ARB_WATCHDOG_EN
  // The counter restarts on entry to Running and advances once per Running
  // cycle. The flag is raised on the cycle the counter reaches all-ones. The
  // flag stays set until reset and never influences arbitration.
  localparam logic [WatchdogCountSize-1:0] WdLastBeforeMax =
    {{(WatchdogCountSize-1){1'b1}}, 1'b0};

  logic [WatchdogCountSize-1:0] wd_count;

  always_ff @(posedge clk) begin
    if (sysRstReq) begin
      wd_count        <= '0;
      watchdogExpired <= 1'b0;
    end else begin
      if (state == ST_ISSUE && kernel_go_fire) begin
        wd_count <= '0;
      end else if (state == ST_RUNNING && wd_count != '1) begin
        wd_count <= wd_count + 1'b1;
      end
      if (state == ST_RUNNING && wd_count == WdLastBeforeMax) begin
        watchdogExpired <= 1'b1;
      end
    end
  end
`else
  // No watchdog is built. The width parameter is still referenced so both
  // builds keep the same parameter list.
  assign watchdogExpired = 1'b0 & (WatchdogCountSize > 0);
`endif

endmodule

// File: tb/tb_sda_kernel_job_arbiter.sv
// Bench for sda_kernel_job_arbiter: directed scenarios followed by a
// randomized phase checked against a job-level reference model.
module tb_sda_kernel_job_arbiter;

  localparam int NR  = 4;
  localparam int OW  = 2;
  localparam int WDW = 4;
`ifdef SDA_JOB_ARB_WATCHDOG_EN
  localparam bit WdOn = 1'b1;
`else
  localparam bit WdOn = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic [NR-1:0] req_go;
  logic [NR-1:0] go_hold;
  logic [NR-1:0] done_vld;
  logic [NR-1:0] done_stop;
  logic          kgo;
  logic          kgh;
  logic          kdv;
  logic          kds;
  logic [OW-1:0] owner;
  logic          busy;
  logic          wd;

  int checks = 0;
  int errors = 0;

  sda_kernel_job_arbiter #(
    .NumReq(NR),
    .OwnerWidth(OW),
    .WatchdogCountSize(WDW)
  ) dut (
    .clk(clk),
    .sysRstReq(rst),
    .reqGoValid(req_go),
    .reqGoHoldoff(go_hold),
    .reqDoneValid(done_vld),
    .reqDoneStop(done_stop),
    .kernelGoValid(kgo),
    .kernelGoHoldoff(kgh),
    .kernelDoneValid(kdv),
    .kernelDoneStop(kds),
    .activeOwner(owner),
    .busy(busy),
    .watchdogExpired(wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Round-robin rule: the first requester after 'last', wrapping around.
  function automatic int rr(input logic [NR-1:0] r, input int last);
    for (int k = 1; k <= NR; k++) begin
      if (r[(last + k) % NR]) return (last + k) % NR;
    end
    return -1;
  endfunction

  // Called in the grant cycle, while the requester's valid is still high.
  // Completes the job with no backpressure.
  task automatic finish_job(input int o, input int run);
    logic [NR-1:0] onehot;
    onehot = '0;
    onehot[o] = 1'b1;
    step();
    req_go[o] = 1'b0;
    chk("fj_kgo", kgo, 1);
    step();
    chk("fj_kstop_low", kds, 0);
    repeat (run) step();
    kdv = 1'b1;
    step();
    kdv = 1'b0;
    chk("fj_done_route", done_vld, onehot);
    step();
    chk("fj_idle", busy, 0);
  endtask

  int            gw;
  int            jobs;
  int            k_wait;
  int            m_last, m_acc, m_go, m_run, m_ret, run_cnt;
  int            n_last, n_acc, n_go, n_run, n_ret, n_cnt;
  bit            m_busy, n_busy, m_wd, n_wd;
  logic [NR-1:0] clr;
  logic [NR-1:0] exp_hold;
  logic [NR-1:0] exp_done;

  initial begin
    rst = 1'b1; req_go = '0; done_stop = '0; kgh = 1'b0; kdv = 1'b0;
    step();
    step();
    chk("rst_holdoff", go_hold, 4'b1111);
    chk("rst_kgo", kgo, 0);
    chk("rst_kstop", kds, 1);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_done", done_vld, 0);
    chk("rst_wd", wd, 0);
    rst = 1'b0;
    step();

    // Single job for requester 2, kernel done pulsed at cycle 10
    req_go = 4'b0100;
    step();
    chk("sj_holdoff", go_hold, 4'b1011);
    chk("sj_owner", owner, 2);
    chk("sj_kgo_early", kgo, 0);
    step();
    req_go = 4'b0000;
    chk("sj_kgo", kgo, 1);
    chk("sj_holdoff_back", go_hold, 4'b1111);
    step();
    chk("sj_kgo_drop", kgo, 0);
    chk("sj_kstop_low", kds, 0);
    repeat (7) step();
    kdv = 1'b1;
    step();
    kdv = 1'b0;
    chk("sj_done", done_vld, 4'b0100);
    chk("sj_kstop_set", kds, 1);
    step();
    chk("sj_done_one_cycle", done_vld, 0);
    chk("sj_idle", busy, 0);

    // Round-robin with every requester asserting: expected order 0,1,2,3,0
    do_reset();
    for (int k = 0; k < 5; k++) begin
      req_go = 4'b1111;
      step();
      gw = -1;
      for (int j = 0; j < NR; j++) if (!go_hold[j]) gw = j;
      chk("rr_order", gw, k % NR);
      chk("rr_owner", owner, k % NR);
      finish_job((gw < 0) ? 0 : gw, 2);
    end

    // Kernel go holdoff for 5 cycles; accepted on the 6th
    req_go = 4'b0001;
    step();
    chk("bp_grant", go_hold, 4'b1110);
    kgh = 1'b1;
    step();
    req_go = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      chk("bp_kgo_held", kgo, 1);
      step();
    end
    chk("bp_kgo_still", kgo, 1);
    kgh = 1'b0;
    step();
    chk("bp_kgo_taken", kgo, 0);
    chk("bp_running", kds, 0);

    // Done stop for 3 cycles while requester 1 waits
    done_stop = 4'b0001;
    req_go = 4'b0010;
    kdv = 1'b1;
    step();
    kdv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("ds_done_held", done_vld, 4'b0001);
      chk("ds_no_grant", go_hold, 4'b1111);
      step();
    end
    chk("ds_done_last", done_vld, 4'b0001);
    done_stop = 4'b0000;
    step();
    chk("ds_done_clear", done_vld, 0);
    chk("ds_idle", busy, 0);
    step();
    chk("ds_next_grant", go_hold, 4'b1101);

    // Reset while requester 1's job is running
    step();
    req_go = 4'b0000;
    chk("mr_kgo", kgo, 1);
    step();
    chk("mr_owner", owner, 1);
    chk("mr_running", kds, 0);
    kdv = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    kdv = 1'b0;
    chk("mr_holdoff", go_hold, 4'b1111);
    chk("mr_done", done_vld, 0);
    chk("mr_kgo_rst", kgo, 0);
    chk("mr_kstop", kds, 1);
    chk("mr_busy", busy, 0);
    chk("mr_owner_rst", owner, 0);
    step();
    chk("mr_no_done", done_vld, 0);
    chk("mr_still_idle", busy, 0);

    // Requester drops valid while granted: no job, last owner unchanged (3)
    req_go = 4'b0100;
    step();
    chk("pv_grant", go_hold, 4'b1011);
    req_go = 4'b0000;
    step();
    chk("pv_idle", busy, 0);
    chk("pv_no_kgo", kgo, 0);
    chk("pv_holdoff", go_hold, 4'b1111);
    req_go = 4'b1001;
    step();
    chk("pv_rr_from0", go_hold, 4'b1110);
    chk("pv_owner", owner, 0);
    finish_job(0, 3);
    req_go = 4'b0000;

    // Randomized phase against the job-level model
    do_reset();
    m_last = NR - 1; m_acc = -1; m_go = -1; m_run = -1; m_ret = -1;
    m_busy = 1'b0; m_wd = 1'b0; run_cnt = 0; clr = '0; jobs = 0; k_wait = 0;
    for (int it = 0; it < 800; it++) begin
      exp_hold = 4'b1111;
      if (m_acc >= 0) exp_hold[m_acc] = 1'b0;
      exp_done = 4'b0000;
      if (m_ret >= 0) exp_done[m_ret] = 1'b1;
      chk("rnd_holdoff", go_hold, exp_hold);
      if (m_acc >= 0) chk("rnd_owner", owner, m_acc);
      chk("rnd_kgo", kgo, m_go >= 0);
      chk("rnd_kstop", kds, !(m_run >= 0));
      chk("rnd_done", done_vld, exp_done);
      chk("rnd_busy", busy, m_busy);
      chk("rnd_wd", wd, WdOn & m_wd);

      req_go = req_go & ~clr;
      clr = '0;
      for (int j = 0; j < NR; j++) begin
        if (!req_go[j] && $urandom_range(0, 3) == 0) req_go[j] = 1'b1;
      end
      kgh = ($urandom_range(0, 2) == 0);
      done_stop = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      kdv = 1'b0;
      if (m_run >= 0) begin
        if (k_wait == 0) kdv = 1'b1;
        else k_wait--;
      end

      n_acc = -1; n_go = m_go; n_run = m_run; n_ret = m_ret;
      n_busy = m_busy; n_last = m_last; n_cnt = run_cnt; n_wd = m_wd;
      if (!m_busy && req_go != '0) begin
        n_acc = rr(req_go, m_last);
        n_busy = 1'b1;
      end
      if (m_acc >= 0) begin
        n_go = m_acc;
        clr[m_acc] = 1'b1;
      end
      if (m_go >= 0 && !kgh) begin
        n_run = m_go;
        n_go = -1;
        n_cnt = 0;
        k_wait = $urandom_range(0, 20);
      end
      if (m_run >= 0) begin
        n_cnt = run_cnt + 1;
        if (n_cnt >= (1 << WDW) - 1) n_wd = 1'b1;
        if (kdv) begin
          n_ret = m_run;
          n_run = -1;
        end
      end
      if (m_ret >= 0 && !done_stop[m_ret]) begin
        n_ret = -1;
        n_last = m_ret;
        n_busy = 1'b0;
        jobs++;
      end
      step();
      m_acc = n_acc; m_go = n_go; m_run = n_run; m_ret = n_ret;
      m_busy = n_busy; m_last = n_last; run_cnt = n_cnt; m_wd = n_wd;
    end
    chk("rnd_progress", jobs > 20, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
